axi_read_arbiter: RTL and testbench

//  Shares the single AXI read path between four cache-side requesters:
//  0=D-uncached, 1=DCache line, 2=I-uncached, 3=ICache line.

---
 rtl/axi_read_arbiter.sv | 99 +++++++++
 tb/tb_axi_read_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read path among D/I uncached and line requesters,
// fixed priority with instruction starvation promotion and a write-back address guard.
module axi_read_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int LINE_BEATS   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req_valid_i,
    input  logic [127:0]  req_addr_i,
    input  logic [3:0]    req_line_i,
    input  logic          wb_busy_i,
    input  logic [31:0]   wb_addr_i,
    output logic          axi_ren_o,
    output logic [31:0]   axi_raddr_o,
    output logic [3:0]    axi_rlen_o,
    output logic          axi_rready_o,
    input  logic [31:0]   rdata_i,
    input  logic          rdata_valid_i,
    output logic [3:0]    grant_o,
    output logic          beat_valid_o,
    output logic [31:0]   beat_data_o,
    output logic [2:0]    beat_idx_o,
    output logic [3:0]    done_o
);
    localparam int BW = $clog2(LINE_BEATS);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [3:0] RLEN = 4'(LINE_BEATS - 1);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t          state;
    logic [1:0]      owner;
    logic [BW-1:0]   beat_cnt;
    logic [SW-1:0]   starve_cnt;
    logic [3:0]      blocked;
    logic [3:0]      elig;
    logic            inst_pend;
    logic            promote;
    logic [1:0]      win;
    logic [31:0]     addr;
    logic            line;
    logic            last;
    always_comb begin
        blocked = '0;
        for (int i = 0; i < 4; i++)
            blocked[i] = req_line_i[i] && wb_busy_i && req_addr_i[32*i+5 +: 27] == wb_addr_i[31:5];
        elig      = req_valid_i & ~blocked;
        inst_pend = |req_valid_i[3:2];
        promote   = starve_cnt == SW'(STARVE_LIMIT) && |elig[3:2];
        // promoted order is 2>3>0>1, normal order is 0>1>2>3
        win  = promote ? (elig[2] ? 2'd2 : elig[3] ? 2'd3 : elig[0] ? 2'd0 : 2'd1)
                       : (elig[0] ? 2'd0 : elig[1] ? 2'd1 : elig[2] ? 2'd2 : 2'd3);
        addr = req_addr_i[32*owner +: 32];
        line = req_line_i[owner];
        last = !line || beat_cnt == BW'(LINE_BEATS - 1);
    end
    assign axi_ren_o    = state == BUSY;
    assign axi_rready_o = axi_ren_o;
    assign axi_raddr_o  = !axi_ren_o ? 32'd0 : line ? {addr[31:BW+2], beat_cnt, 2'b00} : addr;
    assign axi_rlen_o   = axi_ren_o && line ? RLEN : 4'd0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner        <= '0;
            beat_cnt     <= '0;
            starve_cnt   <= '0;
            grant_o      <= '0;
            beat_valid_o <= 1'b0;
            beat_data_o  <= '0;
            beat_idx_o   <= '0;
            done_o       <= '0;
        end else begin
            done_o       <= '0;
            beat_valid_o <= 1'b0;
            if (!inst_pend)
                starve_cnt <= '0;
            if (state == IDLE) begin
                if (|elig) begin
                    owner   <= win;
                    grant_o <= 4'b0001 << win;
                    state   <= BUSY;
                    if (win[1])
                        starve_cnt <= '0;
                    else if (inst_pend && starve_cnt != SW'(STARVE_LIMIT))
                        starve_cnt <= starve_cnt + 1'b1;
                end
            end else if (rdata_valid_i) begin
                beat_valid_o <= 1'b1;
                beat_data_o  <= rdata_i;
                beat_idx_o   <= 3'(beat_cnt);
                beat_cnt     <= last ? '0 : beat_cnt + 1'b1;
                if (last) begin
                    state   <= IDLE;
                    grant_o <= '0;
                    done_o  <= 4'b0001 << owner;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed checks of arbitration, bursts, starvation, wb guard, reset.
module tb_axi_read_arbiter;
    logic         clk = 0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [127:0] req_addr;
    logic [3:0]   req_line;
    logic         wb_busy;
    logic [31:0]  wb_addr;
    logic         axi_ren;
    logic [31:0]  axi_raddr;
    logic [3:0]   axi_rlen;
    logic         axi_rready;
    logic [31:0]  rdata;
    logic         rdata_valid;
    logic [3:0]   grant;
    logic         beat_valid;
    logic [31:0]  beat_data;
    logic [2:0]   beat_idx;
    logic [3:0]   done;
    int checks = 0;
    int errors = 0;

    axi_read_arbiter dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
        .req_line_i(req_line), .wb_busy_i(wb_busy), .wb_addr_i(wb_addr),
        .axi_ren_o(axi_ren), .axi_raddr_o(axi_raddr), .axi_rlen_o(axi_rlen),
        .axi_rready_o(axi_rready), .rdata_i(rdata), .rdata_valid_i(rdata_valid),
        .grant_o(grant), .beat_valid_o(beat_valid), .beat_data_o(beat_data),
        .beat_idx_o(beat_idx), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] a, input logic [2:0] idx, input logic [3:0] d);
        rdata_valid = 1'b1;
        rdata = 32'hD000_0000 ^ a;
        chk("raddr", axi_raddr, a);
        step();
        rdata_valid = 1'b0;
        chk("beat_valid", {31'd0, beat_valid}, 32'd1);
        chk("beat_idx", {29'd0, beat_idx}, {29'd0, idx});
        chk("beat_data", beat_data, 32'hD000_0000 ^ a);
        chk("done", {28'd0, done}, {28'd0, d});
    endtask

    task automatic burst(input logic [31:0] base, input logic [3:0] own);
        chk("rlen_line", {28'd0, axi_rlen}, 32'd7);
        for (int b = 0; b < 8; b++)
            beat(base + 32'(4 * b), 3'(b), b == 7 ? own : 4'd0);
        chk("grant_after_done", {28'd0, grant}, 32'd0);
        chk("ren_after_done", {31'd0, axi_ren}, 32'd0);
    endtask

    initial begin
        rst = 1; req_valid = 0; req_addr = 0; req_line = 0; wb_busy = 0; wb_addr = 0;
        rdata = 0; rdata_valid = 0;
        step(); step();
        rst = 0;
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_ren", {31'd0, axi_ren}, 32'd0);
        chk("rst_done", {28'd0, done}, 32'd0);
        chk("rst_beat_valid", {31'd0, beat_valid}, 32'd0);
        chk("rst_raddr", axi_raddr, 32'd0);

        // only req3 line burst
        req_addr[127:96] = 32'h1000_0040; req_line[3] = 1; req_valid = 4'b1000;
        step();
        chk("t1_grant", {28'd0, grant}, 32'h8);
        chk("t1_ren", {31'd0, axi_ren}, 32'd1);
        chk("t1_rready", {31'd0, axi_rready}, 32'd1);
        burst(32'h1000_0040, 4'b1000);
        req_valid = 0;
        step();
        chk("t1_done_clear", {28'd0, done}, 32'd0);

        // req0 single beats req1 line
        req_addr[31:0] = 32'hBFD0_0000; req_line[0] = 0;
        req_addr[63:32] = 32'h0000_4000; req_line[1] = 1;
        req_valid = 4'b0011;
        step();
        chk("t2_grant0", {28'd0, grant}, 32'h1);
        chk("t2_rlen", {28'd0, axi_rlen}, 32'd0);
        beat(32'hBFD0_0000, 3'd0, 4'b0001);
        chk("t2_grant_idle", {28'd0, grant}, 32'd0);
        req_valid = 4'b0010;
        step();
        chk("t2_grant1", {28'd0, grant}, 32'h2);
        burst(32'h0000_4000, 4'b0010);
        req_valid = 0;
        step();

        // req1 streams singles while req3 pends: promotion after 4 data grants
        req_line[1] = 0; req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t3_grant1", {28'd0, grant}, 32'h2);
            beat(32'h0000_4000, 3'd0, 4'b0010);
        end
        chk("t3_starve_full", 32'(dut.starve_cnt), 32'd4);
        step();
        chk("t3_grant3", {28'd0, grant}, 32'h8);
        chk("t3_starve_clear", 32'(dut.starve_cnt), 32'd0);
        req_valid = 4'b1000;
        burst(32'h1000_0040, 4'b1000);
        req_valid = 0;
        step();

        // write-back guard blocks req1 line, req3 proceeds
        wb_busy = 1; wb_addr = 32'h0000_2010;
        req_addr[63:32] = 32'h0000_2000; req_line[1] = 1;
        req_addr[127:96] = 32'h0000_3000;
        req_valid = 4'b1010;
        step();
        chk("t4_grant3", {28'd0, grant}, 32'h8);
        burst(32'h0000_3000, 4'b1000);
        req_valid = 4'b0010;
        step();
        chk("t4_still_blocked", {28'd0, grant}, 32'd0);
        wb_busy = 0;
        step();
        chk("t4_grant1", {28'd0, grant}, 32'h2);
        burst(32'h0000_2000, 4'b0010);
        req_valid = 0;
        step();

        // reset mid-burst
        req_addr[127:96] = 32'h1000_0040; req_valid = 4'b1000;
        step();
        chk("t5_grant", {28'd0, grant}, 32'h8);
        for (int b = 0; b < 4; b++)
            beat(32'h1000_0040 + 32'(4 * b), 3'(b), 4'd0);
        rst = 1;
        step();
        rst = 0; req_valid = 0;
        chk("t5_ren", {31'd0, axi_ren}, 32'd0);
        chk("t5_grant0", {28'd0, grant}, 32'd0);
        chk("t5_done", {28'd0, done}, 32'd0);
        step();
        chk("t5_done_later", {28'd0, done}, 32'd0);

        // rdata_valid while idle is ignored
        rdata_valid = 1; rdata = 32'h1234_5678;
        step();
        rdata_valid = 0;
        chk("t6_beat_valid", {31'd0, beat_valid}, 32'd0);
        chk("t6_beat_cnt", 32'(dut.beat_cnt), 32'd0);
        chk("t6_grant", {28'd0, grant}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
